// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID_REQ,
        ST_ID_WAIT,
        ST_TS_REQ,
        ST_TS_WAIT,
        ST_DONE
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1539279297;

endpackage

// File: rtl/sysid_checker_timer.sv
// Loadable down-counter that saturates at zero and flags when it is there.
module sysid_checker_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches and verifies the system-ID and build timestamp.
// Optional periodic re-check and sticky mismatch flag: define SYSID_CHECKER_PERIODIC_EN.
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int          READ_LATENCY   = 1,
    parameter int          TIMEOUT_CYCLES = 255
`ifdef SYSID_CHECKER_PERIODIC_EN
    ,
    parameter int          RECHECK_CYCLES = 1_000_000
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout
`ifdef SYSID_CHECKER_PERIODIC_EN
    ,
    output logic        mismatch_sticky
`endif
);

    // Timers count down to zero, so they are loaded one short of the cycle count.
    localparam logic [15:0] STALL_LOAD = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  LAT_LOAD   = 2'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_avm_read;
    logic        r_avm_address;
    logic        r_done;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    logic        w_in_req;
    logic        w_in_wait;
    logic        w_accept;
    logic        w_start;
    logic        w_start_acc;
    logic        w_lat_zero;
    logic        w_stall_zero;
    logic        w_stall_expire;
    logic        w_cap_id;
    logic        w_cap_ts;
    logic        w_enter_done;
    logic [31:0] w_ts_final;
    logic        w_id_ok_next;
    logic        w_ts_ok_next;

    assign w_in_req  = (r_state == ST_ID_REQ) || (r_state == ST_TS_REQ);
    assign w_in_wait = (r_state == ST_ID_WAIT) || (r_state == ST_TS_WAIT);
    assign w_accept  = r_avm_read && !avm_waitrequest;

    sysid_checker_timer #(.WIDTH(2)) u_latency (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_accept),
        .i_load_value (LAT_LOAD),
        .i_dec        (w_in_wait),
        .o_zero       (w_lat_zero)
    );

    // Reloaded whenever no request is stalling, so each read gets a fresh budget.
    sysid_checker_timer #(.WIDTH(16)) u_stall (
        .clock        (clock),
        .reset        (reset),
        .i_load       (!w_in_req || w_accept),
        .i_load_value (STALL_LOAD),
        .i_dec        (w_in_req && avm_waitrequest),
        .o_zero       (w_stall_zero)
    );

    assign w_stall_expire = w_in_req && avm_waitrequest && w_stall_zero;

`ifdef SYSID_CHECKER_PERIODIC_EN
    logic w_recheck_zero;
    logic r_mismatch_sticky;

    sysid_checker_timer #(.WIDTH(32)) u_recheck (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_recheck_zero),
        .i_load_value (32'(RECHECK_CYCLES - 1)),
        .i_dec        (1'b1),
        .o_zero       (w_recheck_zero)
    );

    assign w_start = start || ((r_state == ST_IDLE) && r_done && w_recheck_zero);
`else
    assign w_start = start;
`endif

    assign w_start_acc = (r_state == ST_IDLE) && w_start;

    assign w_cap_id = ((r_state == ST_ID_REQ) && w_accept && (READ_LATENCY == 0))
                   || ((r_state == ST_ID_WAIT) && w_lat_zero);
    assign w_cap_ts = ((r_state == ST_TS_REQ) && w_accept && (READ_LATENCY == 0))
                   || ((r_state == ST_TS_WAIT) && w_lat_zero);

    always_comb begin
        // NOTE: default first so every path assigns the next state and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_next = ST_ID_REQ;
            end
            ST_ID_REQ: begin
                if (w_stall_expire) w_state_next = ST_DONE;
                else if (w_accept) w_state_next = (READ_LATENCY == 0) ? ST_TS_REQ : ST_ID_WAIT;
            end
            ST_ID_WAIT: begin
                if (w_lat_zero) w_state_next = ST_TS_REQ;
            end
            ST_TS_REQ: begin
                if (w_stall_expire) w_state_next = ST_DONE;
                else if (w_accept) w_state_next = (READ_LATENCY == 0) ? ST_DONE : ST_TS_WAIT;
            end
            ST_TS_WAIT: begin
                if (w_lat_zero) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_enter_done = (w_state_next == ST_DONE);
    assign w_ts_final   = w_cap_ts ? avm_readdata : r_ts_value;
    assign w_id_ok_next = !w_stall_expire && (r_id_value == EXPECTED_ID);
    assign w_ts_ok_next = !w_stall_expire && (w_ts_final == EXPECTED_TS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_avm_read    <= 1'b0;
            r_avm_address <= SYSID_ADDR_ID;
        end else begin
            r_state       <= w_state_next;
            r_avm_read    <= (w_state_next == ST_ID_REQ) || (w_state_next == ST_TS_REQ);
            r_avm_address <= (w_state_next == ST_TS_REQ) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_done     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
        end else if (w_start_acc) begin
            r_done     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
        end else begin
            if (w_cap_id)       r_id_value <= avm_readdata;
            if (w_cap_ts)       r_ts_value <= avm_readdata;
            if (w_stall_expire) r_timeout  <= 1'b1;
            if (w_enter_done) begin
                r_done  <= 1'b1;
                r_id_ok <= w_id_ok_next;
                r_ts_ok <= w_ts_ok_next;
            end
        end
    end

`ifdef SYSID_CHECKER_PERIODIC_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mismatch_sticky <= 1'b0;
        end else if (w_enter_done && (!w_id_ok_next || !w_ts_ok_next)) begin
            r_mismatch_sticky <= 1'b1;
        end
    end

    assign mismatch_sticky = r_mismatch_sticky;
`endif

    assign avm_read    = r_avm_read;
    assign avm_address = r_avm_address;
    assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done        = r_done;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: three builds (latency 1/timeout 4, latency 0, latency 3) share stimulus.
module tb_sysid_checker;

    localparam int          NI      = 3;
    localparam logic [31:0] JUNK    = 32'hA5A5_5A5A;
    localparam logic [31:0] GOOD_ID = 32'd0;
    localparam logic [31:0] GOOD_TS = 32'd1539279297;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clock = ~clock;

    int          id_stall_cfg = 0;
    int          ts_stall_cfg = 0;
    logic [31:0] id_word_cfg  = GOOD_ID;
    logic [31:0] ts_word_cfg  = GOOD_TS;

    logic        rd[NI], addr[NI], wreq[NI], busy[NI], done[NI];
    logic        id_ok[NI], ts_ok[NI], tmo[NI];
    logic [31:0] rdata[NI], idv[NI], tsv[NI];
`ifdef SYSID_CHECKER_PERIODIC_EN
    logic        msticky[NI];
`endif

    int errors = 0;
    int checks = 0;
    int meas_done[NI], meas_rd0[NI], meas_rd1[NI];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 3;
    endfunction

    function automatic int tmo_of(input int k);
        return (k == 0) ? 4 : 255;
    endfunction

    // Slave model per build: programmable stall per read, data valid only in its one latency slot.
    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        localparam int T = (g == 0) ? 4 : 255;
        int   stall_left;
        int   rem;
        logic pend;
        logic paddr;

        always @(posedge clock or posedge reset) begin
            if (reset) begin
                stall_left <= 0;
                rem        <= 0;
                pend       <= 1'b0;
                paddr      <= 1'b0;
            end else begin
                if (start) stall_left <= id_stall_cfg;
                else if (rd[g] && stall_left != 0) stall_left <= stall_left - 1;
                else if (rd[g] && !addr[g]) stall_left <= ts_stall_cfg;
                if (pend) begin
                    if (rem == 0) pend <= 1'b0;
                    else rem <= rem - 1;
                end
                if (rd[g] && !wreq[g] && L > 0) begin
                    pend  <= 1'b1;
                    rem   <= L - 1;
                    paddr <= addr[g];
                end
            end
        end

        assign wreq[g]  = rd[g] && (stall_left != 0);
        assign rdata[g] = (L == 0)
            ? ((rd[g] && !wreq[g]) ? (addr[g] ? ts_word_cfg : id_word_cfg) : JUNK)
            : ((pend && rem == 0) ? (paddr ? ts_word_cfg : id_word_cfg) : JUNK);

        sysid_checker #(
            .READ_LATENCY   (L),
            .TIMEOUT_CYCLES (T)
        ) u_dut (
            .clock           (clock),
            .reset           (reset),
            .start           (start),
            .avm_address     (addr[g]),
            .avm_read        (rd[g]),
            .avm_waitrequest (wreq[g]),
            .avm_readdata    (rdata[g]),
            .busy            (busy[g]),
            .done            (done[g]),
            .id_value        (idv[g]),
            .ts_value        (tsv[g]),
            .id_ok           (id_ok[g]),
            .ts_ok           (ts_ok[g]),
            .timeout         (tmo[g])
`ifdef SYSID_CHECKER_PERIODIC_EN
            ,
            .mismatch_sticky (msticky[g])
`endif
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference outcome derived from the protocol rules: phase lengths and timeout budget.
    typedef struct {
        int          done_cyc;
        logic [31:0] id_v;
        logic [31:0] ts_v;
        logic        id_ok;
        logic        ts_ok;
        logic        to;
        int          rd0;
        int          rd1;
    } exp_t;

    function automatic exp_t model(input int L, input int T, input int ids, input int tss,
                                   input logic [31:0] idw, input logic [31:0] tsw);
        exp_t e;
        e.id_v = '0; e.ts_v = '0; e.to = 1'b0; e.rd0 = 0; e.rd1 = 0;
        if (ids >= T) begin
            e.to = 1'b1; e.rd0 = T; e.done_cyc = 1 + T;
        end else begin
            e.id_v = idw; e.rd0 = ids + 1;
            if (tss >= T) begin
                e.to = 1'b1; e.rd1 = T; e.done_cyc = 1 + (ids + 1 + L) + T;
            end else begin
                e.ts_v = tsw; e.rd1 = tss + 1; e.done_cyc = 1 + (ids + 1 + L) + (tss + 1 + L);
            end
        end
        e.id_ok = !e.to && (e.id_v == GOOD_ID);
        e.ts_ok = !e.to && (e.ts_v == GOOD_TS);
        return e;
    endfunction

    task automatic run_check(input int ids, input int tss, input logic [31:0] idw,
                             input logic [31:0] tsw, input string tag);
        exp_t e;
        bit   all_done;
        id_stall_cfg = ids; ts_stall_cfg = tss; id_word_cfg = idw; ts_word_cfg = tsw;
        for (int k = 0; k < NI; k++) begin
            meas_done[k] = -1; meas_rd0[k] = 0; meas_rd1[k] = 0;
        end
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 700; cyc++) begin
            @(negedge clock);
            all_done = 1'b1;
            for (int k = 0; k < NI; k++) begin
                if (meas_done[k] < 0) begin
                    if (done[k]) begin
                        meas_done[k] = cyc;
                    end else begin
                        all_done = 1'b0;
                        if (rd[k] && !addr[k]) meas_rd0[k]++;
                        if (rd[k] && addr[k])  meas_rd1[k]++;
                    end
                end
            end
            if (all_done) break;
        end
        @(negedge clock);
        for (int k = 0; k < NI; k++) begin
            e = model(lat_of(k), tmo_of(k), ids, tss, idw, tsw);
            check($sformatf("%s[%0d] done_cycle", tag, k), 32'(meas_done[k]), 32'(e.done_cyc));
            check($sformatf("%s[%0d] id_value", tag, k), idv[k], e.id_v);
            check($sformatf("%s[%0d] ts_value", tag, k), tsv[k], e.ts_v);
            check($sformatf("%s[%0d] id_ok", tag, k), 32'(id_ok[k]), 32'(e.id_ok));
            check($sformatf("%s[%0d] ts_ok", tag, k), 32'(ts_ok[k]), 32'(e.ts_ok));
            check($sformatf("%s[%0d] timeout", tag, k), 32'(tmo[k]), 32'(e.to));
            check($sformatf("%s[%0d] id_read_cycles", tag, k), 32'(meas_rd0[k]), 32'(e.rd0));
            check($sformatf("%s[%0d] ts_read_cycles", tag, k), 32'(meas_rd1[k]), 32'(e.rd1));
            check($sformatf("%s[%0d] idle_busy", tag, k), 32'(busy[k]), 32'd0);
            check($sformatf("%s[%0d] idle_read", tag, k), 32'(rd[k]), 32'd0);
        end
    endtask

    typedef struct {
        int          ids;
        int          tss;
        logic [31:0] idw;
        logic [31:0] tsw;
        int          done_l1;
        logic        id_ok;
        logic        ts_ok;
        logic        to;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected values for the latency-1 / timeout-4 build.
        vecs[0] = '{ids: 0,    tss: 0,    idw: GOOD_ID, tsw: GOOD_TS,      done_l1: 5, id_ok: 1, ts_ok: 1, to: 0};
        vecs[1] = '{ids: 0,    tss: 0,    idw: GOOD_ID, tsw: GOOD_TS + 1,  done_l1: 5, id_ok: 1, ts_ok: 0, to: 0};
        vecs[2] = '{ids: 3,    tss: 0,    idw: GOOD_ID, tsw: GOOD_TS,      done_l1: 8, id_ok: 1, ts_ok: 1, to: 0};
        vecs[3] = '{ids: 1000, tss: 0,    idw: GOOD_ID, tsw: GOOD_TS,      done_l1: 5, id_ok: 0, ts_ok: 0, to: 1};
        vecs[4] = '{ids: 0,    tss: 2,    idw: 32'h5,   tsw: GOOD_TS,      done_l1: 7, id_ok: 0, ts_ok: 1, to: 0};
        vecs[5] = '{ids: 0,    tss: 1000, idw: GOOD_ID, tsw: GOOD_TS,      done_l1: 7, id_ok: 0, ts_ok: 0, to: 1};

        repeat (2) @(negedge clock);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset[%0d] read", k), 32'(rd[k]), 32'd0);
            check($sformatf("reset[%0d] address", k), 32'(addr[k]), 32'd0);
            check($sformatf("reset[%0d] busy", k), 32'(busy[k]), 32'd0);
            check($sformatf("reset[%0d] done", k), 32'(done[k]), 32'd0);
            check($sformatf("reset[%0d] flags", k), {id_ok[k], ts_ok[k], tmo[k]}, 32'd0);
            check($sformatf("reset[%0d] values", k), idv[k] | tsv[k], 32'd0);
        end
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_check(vecs[v].ids, vecs[v].tss, vecs[v].idw, vecs[v].tsw, $sformatf("vec%0d", v));
            check($sformatf("vec%0d tbl done_cycle", v), 32'(meas_done[0]), 32'(vecs[v].done_l1));
            check($sformatf("vec%0d tbl id_ok", v), 32'(id_ok[0]), 32'(vecs[v].id_ok));
            check($sformatf("vec%0d tbl ts_ok", v), 32'(ts_ok[0]), 32'(vecs[v].ts_ok));
            check($sformatf("vec%0d tbl timeout", v), 32'(tmo[0]), 32'(vecs[v].to));
            repeat (2) @(negedge clock);
        end

        // start during the DONE cycle of build 0 must be ignored.
        id_stall_cfg = 0; ts_stall_cfg = 0; id_word_cfg = GOOD_ID; ts_word_cfg = GOOD_TS;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (5) @(negedge clock);
        check("done_cycle_start done", 32'(done[0]), 32'd1);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (2) @(negedge clock);
        check("done_cycle_start busy", 32'(busy[0]), 32'd0);
        check("done_cycle_start read", 32'(rd[0]), 32'd0);
        check("done_cycle_start done_hold", 32'(done[0]), 32'd1);
        check("done_cycle_start ts_hold", tsv[0], GOOD_TS);
        repeat (20) @(negedge clock);

        // start held every cycle, then reset in TS_WAIT of build 0.
        start = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clock);
            check($sformatf("hold_start c%0d busy", cyc), 32'(busy[0]), 32'd1);
            if (cyc == 2) check("hold_start c2 read", 32'(rd[0]), 32'd0);
            if (cyc == 3) check("hold_start c3 ts_read", {rd[0], addr[0]}, 32'd3);
        end
        check("hold_start c4 read", 32'(rd[0]), 32'd0);
        start = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("async_reset busy", 32'(busy[0]), 32'd0);
        check("async_reset read", 32'(rd[0]), 32'd0);
        check("async_reset done", 32'(done[0]), 32'd0);
        check("async_reset id_value", idv[0], 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Reset with done=1, then reset during a stalled ID read.
        run_check(0, 0, GOOD_ID, GOOD_TS, "pre_reset");
        #1 reset = 1'b1;
        #1;
        check("reset_done done", 32'(done[0]), 32'd0);
        check("reset_done ts_value", tsv[0], 32'd0);
        @(negedge clock);
        reset = 1'b0;
        id_stall_cfg = 1000;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        check("stall_reset read_before", 32'(rd[0]), 32'd1);
        #1 reset = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("stall_reset[%0d] read", k), 32'(rd[k]), 32'd0);
            check($sformatf("stall_reset[%0d] busy", k), 32'(busy[k]), 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;

        for (int n = 0; n < 20; n++) begin
            int          ids, tss;
            logic [31:0] idw, tsw;
            ids = ($urandom_range(0, 9) == 0) ? 300 : int'($urandom_range(0, 5));
            tss = ($urandom_range(0, 9) == 0) ? 300 : int'($urandom_range(0, 5));
            idw = ($urandom_range(0, 1) == 1) ? GOOD_ID : $urandom;
            tsw = ($urandom_range(0, 1) == 1) ? GOOD_TS : $urandom;
            run_check(ids, tss, idw, tsw, $sformatf("rnd%0d", n));
            repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
